serial_word_feeder: RTL and testbench

//   Parallel-to-serial stage that sits directly upstream of the 1-bit shift-register chain and drives its in1 input.

---
 rtl/serial_word_feeder.sv | 136 +++++++++++++
 tb/tb_serial_word_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts a WIDTH-bit word over valid/ready and emits it one bit per clock.
// Optional even-parity trailer bit when SERIAL_WORD_FEEDER_PARITY_EN is defined.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             last_bit;
  logic             accept;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    last_bit = (state_q == PARITY);
`else
    last_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif
    in_ready = (state_q == IDLE) | last_bit;
    accept   = in_valid & in_ready;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      SHIFT: begin
        if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: ;
    endcase

    // A load on the final bit overrides the return to IDLE, giving gapless streaming.
    if (accept) begin
      state_d = SHIFT;
      shreg_d = in_data;
      cnt_d   = CW'(WIDTH - 1);
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      parity_d = ^in_data;
`endif
    end
  end

  // Outputs are derived from next-state so they can be registered without adding latency.
  always_comb begin
    ser_out_d = IDLE_LVL;
    if (state_d == SHIFT) begin
      ser_out_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
    end
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    else if (state_d == PARITY) begin
      ser_out_d = parity_d;
    end
`endif
    ser_valid_d = (state_d != IDLE);
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    frame_done_d = (state_d == PARITY);
`else
    frame_done_d = (state_d == SHIFT) && (cnt_d == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ser_out_q    <= IDLE_LVL;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: MSB-first and LSB-first instances share stimulus and are
// checked against a bit-queue reference model, a constant vector table and hand-written sequences.
module tb_serial_word_feeder;

  localparam int W = 8;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy_m, so_m, sv_m, fd_m;
  logic rdy_l, so_l, sv_l, fd_l;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LVL(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m), .frame_done(fd_m)
  );

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LVL(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l), .frame_done(fd_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the remaining bits of the current frame, front = bit on the wire now.
  bit qm[$];
  bit ql[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         so, sv, fd, rdy;
  } vec_t;
  vec_t tbl[12];
  int   n_tbl;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void push_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      qm.push_back(w[W-1-i]);
      ql.push_back(w[i]);
    end
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    qm.push_back(^w);
    ql.push_back(^w);
`endif
  endfunction

  task automatic model_edge();
    logic acc;
    if (!rst_n) begin
      qm.delete();
      ql.delete();
    end else begin
      acc = in_valid && (qm.size() <= 1);
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (acc) begin
        push_frame(in_data);
        $display("accept word %02h at %0t", in_data, $time);
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".m.valid"}, sv_m, qm.size() > 0);
    chk({tag, ".m.out"},   so_m, (qm.size() > 0) ? qm[0] : 1'b0);
    chk({tag, ".m.done"},  fd_m, qm.size() == 1);
    chk({tag, ".m.ready"}, rdy_m, qm.size() <= 1);
    chk({tag, ".l.valid"}, sv_l, ql.size() > 0);
    chk({tag, ".l.out"},   so_l, (ql.size() > 0) ? ql[0] : 1'b1);
    chk({tag, ".l.done"},  fd_l, ql.size() == 1);
    chk({tag, ".l.ready"}, rdy_l, ql.size() <= 1);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input string tag);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  function automatic void set(input int i, input logic v, input logic [W-1:0] d,
                              input logic so, input logic sv, input logic fd, input logic rdy);
    tbl[i].v = v; tbl[i].d = d; tbl[i].so = so; tbl[i].sv = sv; tbl[i].fd = fd; tbl[i].rdy = rdy;
  endfunction

  initial begin
    int run, rdy_cnt;

    // 8'hA5 MSB first: 1,0,1,0,0,1,0,1
    set(0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    set(1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    set(2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    set(3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    set(4, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    set(5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    set(6, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    set(7, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    set(8, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    set(9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tbl = 10;
`else
    set(7, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    set(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tbl = 9;
`endif

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;
    step(1'b0, 8'h5A, "idle");

    for (int i = 0; i < n_tbl; i++) begin
      step(tbl[i].v, tbl[i].d, "tbl");
      chk("tbl.ser_out",    so_m,  tbl[i].so);
      chk("tbl.ser_valid",  sv_m,  tbl[i].sv);
      chk("tbl.frame_done", fd_m,  tbl[i].fd);
      chk("tbl.in_ready",   rdy_m, tbl[i].rdy);
    end

    // Back-to-back FF then 00 with in_valid held high
    run = 0;
    rdy_cnt = 0;
    step(1'b1, 8'hFF, "b2b");
    if (sv_m) run++;
    if (sv_m && rdy_m) rdy_cnt++;
    for (int i = 0; i < FL; i++) begin
      step(1'b1, 8'h00, "b2b");
      if (sv_m) run++;
      if (sv_m && rdy_m) rdy_cnt++;
    end
    for (int i = 0; i < FL; i++) begin
      step(1'b0, 8'h00, "b2b");
      if (sv_m) run++;
      if (sv_m && rdy_m) rdy_cnt++;
    end
    chk_int("b2b.valid_run", run, 2 * FL);
    chk_int("b2b.ready_cycles", rdy_cnt, 2);

    // LSB-first single word 8'h01
    step(1'b1, 8'h01, "lsb");
    chk("lsb.first_bit", so_l, 1'b1);
    for (int i = 0; i < FL; i++) step(1'b0, 8'h00, "lsb");

    // Reset mid-frame after 3 bits of 8'hC3
    step(1'b1, 8'hC3, "rstmid");
    step(1'b0, 8'h00, "rstmid");
    step(1'b0, 8'h00, "rstmid");
    rst_n = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    check_model("rstmid.async");
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model("rstmid.held");
    rst_n = 1'b1;
    step(1'b1, 8'h3C, "after_rst");
    for (int i = 0; i < FL; i++) step(1'b0, 8'h00, "after_rst");

`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    step(1'b1, 8'h07, "parity");
    for (int i = 0; i < FL - 1; i++) step(1'b0, 8'h00, "parity");
    chk("parity.bit", so_m, 1'b1);
    chk("parity.done", fd_m, 1'b1);
    step(1'b0, 8'h00, "parity");
`endif

    // Randomized traffic with occasional async resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(99) == 0) begin
        rst_n = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        check_model("rnd.rst");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step($urandom_range(9) < 7, W'($urandom), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
